// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants for the SPI target block: bus register offsets, CTRL and
// STATUS bit positions, and the two-state shift FSM encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

   // Register map, selected by the 2-bit offset
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_TXDATA = 2'd1;
   localparam logic [1:0] OFF_RXDATA = 2'd2;
   localparam logic [1:0] OFF_STATUS = 2'd3;

   // CTRL bits
   localparam int CTRL_EN_BIT = 0;
   localparam int CTRL_IE_BIT = 2;

   // STATUS bits
   localparam int ST_BUSY_BIT     = 0;
   localparam int ST_RX_VALID_BIT = 1;
   localparam int ST_OVERRUN_BIT  = 2;
   localparam int ST_TX_EMPTY_BIT = 3;

   // Shift FSM encoding
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchronizer for one asynchronous pin, plus single-cycle rise and
// fall pulses derived from the synchronized value.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   async_i      raw pin
//   sync_o       synchronized pin (2 flops of latency)
//   rise_o       1-cycle pulse on a synchronized 0->1 transition
//   fall_o       1-cycle pulse on a synchronized 1->0 transition
// Parameter RST_VAL is the idle level of the pin, loaded into every stage.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic       meta_q;
   logic       sync_q;
   logic       hist_q;
   logic [1:0] prime_q;
   logic       primed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= RST_VAL;
         sync_q  <= RST_VAL;
         hist_q  <= RST_VAL;
         prime_q <= 2'd0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         hist_q <= sync_q;
         if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
      end
   end

   // Edges are suppressed until both sync_q and hist_q hold real pin samples.
   // Without this, a pin that sits at the non-idle level through reset would
   // look like a fresh edge once the reset value drains out of the pipeline.
   assign primed = (prime_q == 2'd3);
   assign sync_o = sync_q;
   assign rise_o = primed &  sync_q & ~hist_q;
   assign fall_o = primed & ~sync_q &  hist_q;

endmodule

// File: rtl/spi_slave_ip.sv
// -----------------------------------------------------------------------------
// spi_slave_ip
// Memory-mapped SPI target, mode 0 (CPOL=0, CPHA=0), 8-bit, MSB first.
// The SPI pins are synchronized into clk; a two-state FSM (IDLE/SHIFT,
// held in state_q) shifts mosi into RXDATA and the TXDATA byte out on miso.
// Optional feature macro: SPI_SLAVE_IRQ_EN adds the irq port and CTRL.IE.
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   sel, w_en, r_en        bus select and strobes (strobes qualified by sel)
//   offset, wdata, rdata   0 CTRL, 1 TXDATA, 2 RXDATA, 3 STATUS; rdata is
//                          combinational and 0 when no read is strobed
//   sclk, mosi, cs_n       SPI pins from the external master
//   miso, miso_oe          SPI data to the master and its buffer enable
//   irq                    (SPI_SLAVE_IRQ_EN only) IE & (RX_VALID | OVERRUN)
// Bus handshake: a register access is a single cycle with sel & w_en or
// sel & r_en high; writes and read side effects land on the closing clk edge.
// -----------------------------------------------------------------------------
module spi_slave_ip
   import spi_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sel,
   input  logic        w_en,
   input  logic        r_en,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        sclk,
   input  logic        mosi,
   input  logic        cs_n,
   output logic        miso,
`ifdef SPI_SLAVE_IRQ_EN
   output logic        irq,
`endif
   output logic        miso_oe
);

   logic sclk_sync_unused, sclk_rise, sclk_fall;
   logic cs_sync, cs_rise, cs_fall;
   logic mosi_meta_q, mosi_sync_q;
   logic wdata_unused;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .rst_n(rst_n), .async_i(sclk),
      .sync_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst_n(rst_n), .async_i(cs_n),
      .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   // mosi gets the same two flops, so it lines up with the sclk edge pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
      end else begin
         mosi_meta_q <= mosi;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   assign wdata_unused = ^wdata[31:8];

   logic       en_q, en_d;
   logic [7:0] txdata_q, txdata_d;
   logic [7:0] rxdata_q, rxdata_d;
   logic       rx_valid_q, rx_valid_d;
   logic       overrun_q, overrun_d;
   logic       tx_empty_q, tx_empty_d;
   logic [0:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shadow_q, shadow_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic       miso_q, miso_d;
`ifdef SPI_SLAVE_IRQ_EN
   logic       ie_q, ie_d;
   logic       irq_q;
`endif

   logic       wr, rd, load;
   logic [7:0] tx_src;

   assign wr = sel & w_en;
   assign rd = sel & r_en;
   // A TXDATA write landing on the same edge as a shadow load feeds the shadow.
   assign tx_src = (wr && offset == OFF_TXDATA) ? wdata[7:0] : txdata_q;

   always_comb begin
      en_d       = en_q;
      txdata_d   = txdata_q;
      rxdata_d   = rxdata_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
      tx_empty_d = tx_empty_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      rx_shift_d = rx_shift_q;
      miso_d     = miso_q;
      load       = 1'b0;
`ifdef SPI_SLAVE_IRQ_EN
      ie_d       = ie_q;
`endif

      // Bus side; SPI-side sets below come later so they win any collision.
      if (wr && offset == OFF_CTRL) begin
         en_d = wdata[CTRL_EN_BIT];
`ifdef SPI_SLAVE_IRQ_EN
         ie_d = wdata[CTRL_IE_BIT];
`endif
      end
      if (wr && offset == OFF_TXDATA) begin
         txdata_d   = wdata[7:0];
         tx_empty_d = 1'b0;
      end
      if (wr && offset == OFF_STATUS && wdata[ST_OVERRUN_BIT]) overrun_d = 1'b0;
      if (rd && offset == OFF_RXDATA) rx_valid_d = 1'b0;

      if (!en_q) begin
         state_d = ST_IDLE;
         cnt_d   = 4'd0;
         miso_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_d = ST_SHIFT;
                  cnt_d   = 4'd0;
                  load    = 1'b1;
               end
            end
            ST_SHIFT: begin
               if (cs_rise) begin
                  // Any partial byte is simply dropped.
                  state_d = ST_IDLE;
                  cnt_d   = 4'd0;
                  miso_d  = 1'b0;
               end else if (sclk_rise) begin
                  rx_shift_d = {rx_shift_q[6:0], mosi_sync_q};
                  cnt_d      = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     rxdata_d   = {rx_shift_q[6:0], mosi_sync_q};
                     rx_valid_d = 1'b1;
                     if (rx_valid_q) overrun_d = 1'b1;
                  end
               end else if (sclk_fall) begin
                  if (cnt_q == 4'd8) begin
                     // Byte boundary inside a burst: fetch the next byte.
                     cnt_d = 4'd0;
                     load  = 1'b1;
                  end else if (cnt_q != 4'd0) begin
                     shadow_d = {shadow_q[6:0], 1'b0};
                     miso_d   = shadow_q[6];
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (load) begin
         shadow_d   = tx_src;
         tx_empty_d = 1'b1;
         miso_d     = tx_src[7];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q       <= 1'b0;
         txdata_q   <= 8'h00;
         rxdata_q   <= 8'h00;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         tx_empty_q <= 1'b1;
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         shadow_q   <= 8'h00;
         rx_shift_q <= 8'h00;
         miso_q     <= 1'b0;
      end else begin
         en_q       <= en_d;
         txdata_q   <= txdata_d;
         rxdata_q   <= rxdata_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         tx_empty_q <= tx_empty_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         rx_shift_q <= rx_shift_d;
         miso_q     <= miso_d;
      end
   end

`ifdef SPI_SLAVE_IRQ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie_q  <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         ie_q  <= ie_d;
         irq_q <= ie_q & (rx_valid_q | overrun_q);
      end
   end
   assign irq = irq_q;
`endif

   assign miso_oe = en_q & ~cs_sync;
   assign miso    = miso_q & miso_oe;

   always_comb begin
      rdata = 32'd0;
      if (rd) begin
         case (offset)
            OFF_CTRL: begin
               rdata[CTRL_EN_BIT] = en_q;
`ifdef SPI_SLAVE_IRQ_EN
               rdata[CTRL_IE_BIT] = ie_q;
`endif
            end
            OFF_TXDATA: rdata[7:0] = txdata_q;
            OFF_RXDATA: rdata[7:0] = rxdata_q;
            default: begin
               rdata[ST_BUSY_BIT]     = ~cs_sync;
               rdata[ST_RX_VALID_BIT] = rx_valid_q;
               rdata[ST_OVERRUN_BIT]  = overrun_q;
               rdata[ST_TX_EMPTY_BIT] = tx_empty_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_ip.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_ip
// Bench for spi_slave_ip: a register-access vector table, then hand-written
// SPI master sequences (mode 0, half-period 4 clk) for single byte, burst,
// abort, disabled block, mid-transfer reset and (SPI_SLAVE_IRQ_EN) interrupt.
// -----------------------------------------------------------------------------
module tb_spi_slave_ip;
   import spi_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel, w_en, r_en;
   logic [1:0]  offset;
   logic [31:0] wdata, rdata;
   logic        sclk, mosi, cs_n, miso, miso_oe;
`ifdef SPI_SLAVE_IRQ_EN
   logic        irq;
   localparam logic [31:0] CTRL_ALL = 32'h5;
`else
   localparam logic [31:0] CTRL_ALL = 32'h1;
`endif

   always #5 clk = ~clk;

   spi_slave_ip dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .w_en(w_en), .r_en(r_en),
      .offset(offset), .wdata(wdata), .rdata(rdata),
      .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
`ifdef SPI_SLAVE_IRQ_EN
      .irq(irq),
`endif
      .miso_oe(miso_oe)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sb_check(input string name, input logic [7:0] got);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: got 0x%0h expected <none queued>", name, got);
      end else begin
         check(name, 32'(got), 32'(exp_q.pop_front()));
      end
   endtask

   // ---------------- bus driver ----------------
   task automatic bus_op(input logic wr, input logic [1:0] off, input logic [31:0] wd,
                         output logic [31:0] rd);
      @(negedge clk);
      sel = 1'b1; w_en = wr; r_en = ~wr; offset = off; wdata = wd;
      #1 rd = rdata;
      @(negedge clk);
      sel = 1'b0; w_en = 1'b0; r_en = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] off, input logic [31:0] wd);
      logic [31:0] dummy;
      bus_op(1'b1, off, wd, dummy);
   endtask

   task automatic bus_check(input string name, input logic [1:0] off, input logic [31:0] exp);
      logic [31:0] d;
      bus_op(1'b0, off, 32'd0, d);
      check(name, d, exp);
   endtask

   // ---------------- SPI master driver ----------------
   task automatic cs_low();
      @(negedge clk);
      cs_n = 1'b0;
   endtask

   task automatic cs_high();
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = mo[7-i];
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         mi = {mi[6:0], miso};
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   // ---------------- register vector table ----------------
   typedef struct {
      logic        wr;
      logic [1:0]  off;
      logic [31:0] wd;
      logic [31:0] exp;   // rdata expected during the cycle (0 for writes)
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [31:0] d;
      logic [7:0]  mi;

      vecs[0]  = '{1'b0, OFF_CTRL,   32'h0,        32'h0};
      vecs[1]  = '{1'b0, OFF_TXDATA, 32'h0,        32'h0};
      vecs[2]  = '{1'b0, OFF_RXDATA, 32'h0,        32'h0};
      vecs[3]  = '{1'b0, OFF_STATUS, 32'h0,        32'h8};
      vecs[4]  = '{1'b1, OFF_CTRL,   32'hFFFFFFFF, 32'h0};
      vecs[5]  = '{1'b0, OFF_CTRL,   32'h0,        CTRL_ALL};
      vecs[6]  = '{1'b1, OFF_TXDATA, 32'h000001FF, 32'h0};
      vecs[7]  = '{1'b0, OFF_TXDATA, 32'h0,        32'hFF};
      vecs[8]  = '{1'b0, OFF_STATUS, 32'h0,        32'h0};
      vecs[9]  = '{1'b1, OFF_CTRL,   32'h0,        32'h0};
      vecs[10] = '{1'b1, OFF_STATUS, 32'hF,        32'h0};
      vecs[11] = '{1'b0, OFF_CTRL,   32'h0,        32'h0};

      rst_n = 1'b0;
      sel = 1'b0; w_en = 1'b0; r_en = 1'b0; offset = 2'd0; wdata = 32'd0;
      sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_miso", 32'(miso), 32'h0);
      check("reset_miso_oe", 32'(miso_oe), 32'h0);
      check("reset_rdata", rdata, 32'h0);
`ifdef SPI_SLAVE_IRQ_EN
      check("reset_irq", 32'(irq), 32'h0);
`endif
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         bus_op(vecs[i].wr, vecs[i].off, vecs[i].wd, d);
         check($sformatf("vec%0d", i), d, vecs[i].exp);
      end

      // ---- single byte ----
      bus_write(OFF_CTRL, 32'h1);
      bus_write(OFF_TXDATA, 32'h3C);
      exp_q.push_back(8'h3C);
      cs_low();
      spi_byte(8'hA5, 8, mi);
      sb_check("single_miso", mi);
      bus_check("single_status_busy", OFF_STATUS, 32'h0B);
      cs_high();
      bus_check("single_rxdata", OFF_RXDATA, 32'hA5);
      bus_check("single_status_after_read", OFF_STATUS, 32'h08);

      // ---- burst of two bytes under one cs_n ----
      bus_write(OFF_TXDATA, 32'h11);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      fork
         begin
            logic [7:0] m;
            cs_low();
            spi_byte(8'hF0, 8, m);
            sb_check("burst_miso0", m);
            spi_byte(8'h0F, 8, m);
            sb_check("burst_miso1", m);
            cs_high();
         end
         begin
            repeat (20) @(negedge clk);
            bus_write(OFF_TXDATA, 32'h22);
         end
      join
      bus_check("burst_status", OFF_STATUS, 32'h0E);
      bus_check("burst_rxdata", OFF_RXDATA, 32'h0F);
      bus_write(OFF_STATUS, 32'h4);
      bus_check("burst_w1c", OFF_STATUS, 32'h08);

      // ---- abort after 5 bits, then a clean byte ----
      cs_low();
      spi_byte(8'hFF, 5, mi);
      cs_high();
      bus_check("abort_status", OFF_STATUS, 32'h08);
      bus_check("abort_rxdata_kept", OFF_RXDATA, 32'h0F);
      bus_write(OFF_TXDATA, 32'h96);
      exp_q.push_back(8'h96);
      cs_low();
      spi_byte(8'h5A, 8, mi);
      sb_check("after_abort_miso", mi);
      cs_high();
      bus_check("after_abort_rxdata", OFF_RXDATA, 32'h5A);

      // ---- disabled block ignores the link ----
      bus_write(OFF_CTRL, 32'h0);
      bus_write(OFF_TXDATA, 32'hAB);
      cs_low();
      spi_byte(8'hC5, 8, mi);
      check("dis_miso_oe", 32'(miso_oe), 32'h0);
      check("dis_miso_byte", 32'(mi), 32'h0);
      cs_high();
      bus_check("dis_status", OFF_STATUS, 32'h00);

      // ---- reset mid-byte ----
      bus_write(OFF_CTRL, 32'h1);
      bus_write(OFF_TXDATA, 32'hFF);
      cs_low();
      spi_byte(8'hAA, 4, mi);
      check("pre_rst_miso_oe", 32'(miso_oe), 32'h1);
      check("pre_rst_bits", 32'(mi), 32'h0F);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_miso", 32'(miso), 32'h0);
      check("rst_miso_oe", 32'(miso_oe), 32'h0);
      check("rst_rdata_idle", rdata, 32'h0);
`ifdef SPI_SLAVE_IRQ_EN
      check("rst_irq", 32'(irq), 32'h0);
`endif
      sel = 1'b1; r_en = 1'b1; offset = OFF_STATUS;
      #1 check("rst_status", rdata, 32'h08);
      sel = 1'b0; r_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // cs_n is still low: enabling must not start a transfer without a new fall.
      bus_write(OFF_CTRL, 32'h1);
      repeat (4) @(negedge clk);
      bus_check("post_rst_status", OFF_STATUS, 32'h09);
      spi_byte(8'h77, 8, mi);
      check("post_rst_no_shift", 32'(mi), 32'h0);
      bus_check("post_rst_no_rx", OFF_STATUS, 32'h09);
      cs_high();
      bus_write(OFF_TXDATA, 32'hC3);
      exp_q.push_back(8'hC3);
      cs_low();
      spi_byte(8'h3C, 8, mi);
      sb_check("fresh_miso", mi);
      cs_high();
      bus_check("fresh_status", OFF_STATUS, 32'h0A);
      bus_check("fresh_rxdata", OFF_RXDATA, 32'h3C);

`ifdef SPI_SLAVE_IRQ_EN
      // ---- interrupt ----
      bus_write(OFF_CTRL, 32'h5);
      bus_write(OFF_TXDATA, 32'h00);
      check("irq_idle", 32'(irq), 32'h0);
      cs_low();
      spi_byte(8'h81, 8, mi);
      cs_high();
      check("irq_rise", 32'(irq), 32'h1);
      bus_check("irq_rxdata", OFF_RXDATA, 32'h81);
      check("irq_hold_one_cycle", 32'(irq), 32'h1);
      @(negedge clk);
      check("irq_fall", 32'(irq), 32'h0);
`endif

      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
